// File: rtl/serial_adder.sv
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Digit-serial adder/subtractor, DIGIT bits per cycle, LSB first.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_NUM_DIGITS = WIDTH / DIGIT;
    localparam int c_CNT_W      = $clog2(c_NUM_DIGITS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NUM_DIGITS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    generate
        if ((WIDTH < 2) || (WIDTH > 64) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_err
            $error("serial_adder: WIDTH must be 2..64 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [DIGIT-1:0]   w_a_sl;
    logic [DIGIT-1:0]   w_b_sl;
    logic [DIGIT:0]     w_s;
    logic               w_c_msb;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    assign w_a_sl  = r_a[DIGIT-1:0];
    assign w_b_sl  = r_b[DIGIT-1:0];
    assign w_s     = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{DIGIT{1'b0}}, r_carry};
    // Carry into the top bit of the slice, recovered from its sum bit.
    assign w_c_msb = w_a_sl[DIGIT-1] ^ w_b_sl[DIGIT-1] ^ w_s[DIGIT-1];
    assign w_last  = (r_cnt == c_LAST);

    generate
        if (c_NUM_DIGITS == 1) begin : g_single
            assign w_res_next = w_s[DIGIT-1:0];
        end else begin : g_multi
            assign w_res_next = {w_s[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_state_next = c_RUN;
            c_RUN:   if (w_last) w_state_next = c_DONE;
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == c_IDLE);
        done  = (r_state == c_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                    end
                end
                c_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_s[DIGIT];
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum  <= w_res_next;
                        r_cout <= w_s[DIGIT];
                        r_ovf  <= w_s[DIGIT] ^ w_c_msb;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Directed self-checking bench for serial_adder (8-bit and 16-bit).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, sub, cin;
    logic [7:0] a, b;
    logic       ready, done, cout, ovf;
    logic [7:0] sum;

    logic        st16, sub16, cin16;
    logic [15:0] a16, b16;
    logic        rdy16 [5];
    logic        dn16  [5];
    logic [15:0] s16   [5];
    logic        co16  [5];
    logic        ov16  [5];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .ready(ready), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_dut16
            serial_adder #(.WIDTH(16), .DIGIT(1 << gi)) u_dut (
                .clk(clk), .rst_n(rst_n), .start(st16), .sub(sub16), .a(a16), .b(b16),
                .cin(cin16), .ready(rdy16[gi]), .done(dn16[gi]), .sum(s16[gi]),
                .cout(co16[gi]), .ovf(ov16[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation; junk operands and a stray start are driven while busy.
    task automatic op8(input string tag, input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic [7:0] es, input logic ec, input logic eo);
        int lat = -1;
        int w   = 0;
        while (!ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_rdy_in"}, 64'(ready), 64'(1));
        sub = s; a = av; b = bv; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~av; b = av ^ bv ^ 8'h5A; cin = ~ci; sub = ~s;
        for (int k = 1; k <= 20; k++) begin
            start = (k == 3);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'(8));
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        check({tag, "_busy"}, 64'(ready), 64'(0));
        @(negedge clk);
        check({tag, "_done_end"}, 64'(done), 64'(0));
        check({tag, "_rdy_out"}, 64'(ready), 64'(1));
    endtask

    // Same operation into all five 16-bit instances, DIGIT = 1,2,4,8,16.
    task automatic op16(input string tag, input logic s, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic [15:0] es, input logic ec, input logic eo);
        int lat [5];
        for (int i = 0; i < 5; i++) lat[i] = -1;
        sub16 = s; a16 = av; b16 = bv; cin16 = ci; st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0; a16 = ~av; b16 = ~bv; cin16 = ~ci; sub16 = ~s;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            for (int i = 0; i < 5; i++)
                if (dn16[i] && lat[i] < 0) lat[i] = k;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_d%0d_lat", tag, 1 << i), 64'(lat[i]), 64'(16 >> i));
            check($sformatf("%s_d%0d_sum", tag, 1 << i), 64'(s16[i]), 64'(es));
            check($sformatf("%s_d%0d_cout", tag, 1 << i), 64'(co16[i]), 64'(ec));
            check($sformatf("%s_d%0d_ovf", tag, 1 << i), 64'(ov16[i]), 64'(eo));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int       seen;
        logic [7:0] exp_s;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        st16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
        #3;
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        check("rst16_sum", 64'(s16[2]), 64'(0));
        #9 rst_n = 1'b1;
        @(negedge clk);

        op8("ff_01",   1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("7f_01",   1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("10_20c",  1'b0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
        op8("sub5_7",  1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("80_80",   1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        op8("sub3_3",  1'b1, 8'h03, 8'h03, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("aa_55c",  1'b0, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);

        // start held high: accepts only at edges 0, 10, 20
        for (int k = 0; k < 30; k++) begin
            a = 8'(3 * k + 1); b = 8'(k); sub = 1'b0; cin = 1'b0; start = 1'b1;
            @(negedge clk);
            check($sformatf("strm_done_%0d", k), 64'(done), 64'((k % 10) == 8));
            if (k >= 8) begin
                exp_s = 8'(40 * ((k - 8) / 10) + 1);
                check($sformatf("strm_sum_%0d", k), 64'(sum), 64'(exp_s));
            end
        end
        start = 1'b0;
        @(negedge clk);

        op8("sub80_1", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

        // asynchronous reset in the middle of RUN
        sub = 1'b0; a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sum", 64'(sum), 64'(0));
        check("arst_cout", 64'(cout), 64'(0));
        check("arst_ovf", 64'(ovf), 64'(0));
        check("arst_ready", 64'(ready), 64'(1));
        check("arst_done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("arst_no_done", 64'(seen), 64'(0));
        op8("03_04",   1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        op16("ffff_1",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("1234",    1'b0, 16'h1234, 16'h5678, 1'b0, 16'h68AC, 1'b0, 1'b0);
        op16("s8000",   1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        op16("7fffc",   1'b0, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0, 1'b1);
        op16("s1_2",    1'b1, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, legal range 2..64.
REQ-002 SHALL have parameter DIGIT, default 1: bits added per compute cycle; WIDTH mod DIGIT SHALL be 0, else elaboration fails.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin an operation, sampled on rising edge of clk.
REQ-006 SHALL have port sub  input  1  mode, sampled with start: 0 = a+b+cin, 1 = a-b (cin ignored).
REQ-007 SHALL have port a  input  WIDTH  operand A, sampled with start.
REQ-008 SHALL have port b  input  WIDTH  operand B, sampled with start.
REQ-009 SHALL have port cin  input  1  carry-in for add mode, sampled with start.
REQ-010 SHALL have port ready  output  1  high when a start will be accepted.
REQ-011 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  carry-out (add) / no-borrow (sub).
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; ready = (state == IDLE), done = (state == DONE), both registered-state decodes.
REQ-016 IDLE: start=1 at an edge SHALL latch a, b, cin, sub and move to RUN; start=0 SHALL remain in IDLE.
REQ-017 Accept: internal B operand SHALL be ~b when sub=1, else b; internal carry SHALL be 1 when sub=1, else cin.
REQ-018 RUN: each edge SHALL add one DIGIT-bit slice (LSB slice first) of A, B and the stored carry, shift the slice sum into an internal result register, and update the stored carry.
REQ-019 RUN SHALL last exactly N = WIDTH/DIGIT edges, counted by a counter of ceil(log2(N+1)) bits; the Nth edge SHALL move to DONE.
REQ-020 The edge entering DONE SHALL load sum, cout (final carry) and ovf (carry into MSB XOR carry out of MSB) into the output registers.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-022 Latency: with start accepted at edge 0, done SHALL be high between edges N and N+1; ready SHALL rise after edge N+1; back-to-back issue interval N+2 cycles.
REQ-023 start while ready=0 (RUN or DONE) SHALL be ignored, with no effect on operands, counter or outputs.
REQ-024 sum, cout, ovf SHALL hold their last result from the DONE entry edge until the next DONE entry edge, including during a subsequent RUN.
REQ-025 Input changes on a, b, cin, sub after acceptance SHALL NOT affect the operation in progress.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; the result SHALL equal the single-cycle WIDTH-bit adder result for every DIGIT value.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force state IDLE, counter 0, internal registers 0, sum 0, cout 0, ovf 0; hence ready=1, done=0.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-029 WIDTH=8, DIGIT=1, sub=0: a=8'hFF, b=8'h01, cin=0 -> done 8 cycles after accept edge, sum=8'h00, cout=1, ovf=0.
REQ-030 WIDTH=8, DIGIT=1, sub=0: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1; then a=8'h10, b=8'h20, cin=1 -> sum=8'h31, cout=0, ovf=0.
REQ-031 WIDTH=8, DIGIT=1, sub=1: a=8'h05, b=8'h07, cin=1 -> sum=8'hFE, cout=0, ovf=0; a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
REQ-032 start held high continuously with changing operands -> only operands present at ready=1 edges are used; one done per N+2 cycles; sum stable between done pulses.
REQ-033 rst_n pulsed low at RUN cycle 3 -> outputs zero asynchronously, ready=1, no done pulse; next operation 8'h03+8'h04 -> sum=8'h07.
REQ-034 WIDTH=16, DIGIT=4: a=16'hFFFF, b=16'h0001, cin=0 -> done 4 cycles after accept edge, sum=16'h0000, cout=1; random sweep matches reference model for DIGIT in {1,2,4,8,16}.
